// File: rtl/ahb_decoder_resp.sv
// ahb_decoder_resp: AHB-Lite three-slave address decoder, data-phase select and default-slave response stage
module ahb_decoder_resp #(
    parameter logic [31:0] S1_BASE = 32'h0000_0000,
    parameter logic [31:0] S1_MASK = 32'hF000_0000,
    parameter logic [31:0] S2_BASE = 32'h1000_0000,
    parameter logic [31:0] S2_MASK = 32'hF000_0000,
    parameter logic [31:0] S3_BASE = 32'h2000_0000,
    parameter logic [31:0] S3_MASK = 32'hF000_0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HREADYOUT_I,
    input  logic        HRESP_I,
    output logic [2:0]  HSEL,
    output logic [1:0]  MSEL,
    output logic        HREADY,
    output logic        HRESP
);
    localparam logic [1:0] DS_OKAY = 2'd0;
    localparam logic [1:0] DS_ERR1 = 2'd1;
    localparam logic [1:0] DS_ERR2 = 2'd2;
    logic       hit1, hit2, hit3, unmapped, active, def_sel;
    logic [1:0] state, state_nxt;
    assign hit1 = (HADDR & S1_MASK) == S1_BASE;
    assign hit2 = (HADDR & S2_MASK) == S2_BASE;
    assign hit3 = (HADDR & S3_MASK) == S3_BASE;
    always_comb begin
        HSEL = hit1 ? 3'b001 : hit2 ? 3'b010 : hit3 ? 3'b100 : 3'b000;
    end
    assign unmapped = HSEL == 3'b000;
    assign active   = (HTRANS == 2'b10) || (HTRANS == 2'b11);
    // Data-phase selects only advance when the current data phase completes
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            MSEL    <= 2'b00;
            def_sel <= 1'b1;
        end else if (HREADY) begin
            MSEL    <= HSEL[0] ? 2'b10 : HSEL[1] ? 2'b01 : 2'b00;
            def_sel <= unmapped;
        end
    end
    // ERR1 always proceeds to ERR2; OKAY and ERR2 both sample the next address phase
    always_comb begin
        state_nxt = (state == DS_ERR1) ? DS_ERR2 :
                    (HREADY && unmapped && active) ? DS_ERR1 : DS_OKAY;
    end
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            state <= DS_OKAY;
        else
            state <= state_nxt;
    end
    always_comb begin
        HREADY = def_sel ? (state != DS_ERR1) : HREADYOUT_I;
        HRESP  = def_sel ? (state == DS_ERR1 || state == DS_ERR2) : HRESP_I;
    end
endmodule

// File: tb/tb_ahb_decoder_resp.sv
// tb_ahb_decoder_resp: directed table-driven bench for the AHB decoder/response stage
module tb_ahb_decoder_resp;
    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HREADYOUT_I, HRESP_I;
    logic [2:0]  HSEL;
    logic [1:0]  MSEL;
    logic        HREADY, HRESP;
    int          n_checks = 0;
    int          n_fail = 0;

    ahb_decoder_resp dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
        .HREADYOUT_I(HREADYOUT_I), .HRESP_I(HRESP_I),
        .HSEL(HSEL), .MSEL(MSEL), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        ro;
        logic        ri;
        logic [2:0]  hsel;
        logic [1:0]  msel;
        logic        rdy;
        logic        rsp;
    } vec_t;

    vec_t v[22];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] hs, input logic [1:0] ms,
                             input logic rd, input logic rs);
        check({tag, " HSEL"}, 32'(HSEL), 32'(hs));
        check({tag, " MSEL"}, 32'(MSEL), 32'(ms));
        check({tag, " HREADY"}, 32'(HREADY), 32'(rd));
        check({tag, " HRESP"}, 32'(HRESP), 32'(rs));
    endtask

    initial begin
        v[0]  = '{32'h0000_0004, 2'b10, 1'b1, 1'b0, 3'b001, 2'b00, 1'b1, 1'b0};
        v[1]  = '{32'h1000_0008, 2'b10, 1'b1, 1'b0, 3'b010, 2'b10, 1'b1, 1'b0};
        v[2]  = '{32'h2000_000C, 2'b10, 1'b1, 1'b0, 3'b100, 2'b01, 1'b1, 1'b0};
        v[3]  = '{32'h1000_0010, 2'b10, 1'b1, 1'b0, 3'b010, 2'b00, 1'b1, 1'b0};
        v[4]  = '{32'h0000_0000, 2'b10, 1'b0, 1'b0, 3'b001, 2'b01, 1'b0, 1'b0};
        v[5]  = '{32'h0000_0000, 2'b10, 1'b0, 1'b1, 3'b001, 2'b01, 1'b0, 1'b1};
        v[6]  = '{32'h0000_0000, 2'b10, 1'b1, 1'b1, 3'b001, 2'b01, 1'b1, 1'b1};
        v[7]  = '{32'h3000_0000, 2'b10, 1'b1, 1'b0, 3'b000, 2'b10, 1'b1, 1'b0};
        v[8]  = '{32'h5000_0000, 2'b00, 1'b1, 1'b0, 3'b000, 2'b00, 1'b0, 1'b1};
        v[9]  = '{32'h5000_0000, 2'b00, 1'b1, 1'b0, 3'b000, 2'b00, 1'b1, 1'b1};
        v[10] = '{32'h4000_0000, 2'b00, 1'b1, 1'b0, 3'b000, 2'b00, 1'b1, 1'b0};
        v[11] = '{32'h3000_0004, 2'b10, 1'b1, 1'b0, 3'b000, 2'b00, 1'b1, 1'b0};
        v[12] = '{32'h3000_0008, 2'b11, 1'b1, 1'b0, 3'b000, 2'b00, 1'b0, 1'b1};
        v[13] = '{32'h3000_0008, 2'b11, 1'b1, 1'b0, 3'b000, 2'b00, 1'b1, 1'b1};
        v[14] = '{32'h0000_0000, 2'b10, 1'b1, 1'b0, 3'b001, 2'b00, 1'b0, 1'b1};
        v[15] = '{32'h0000_0000, 2'b10, 1'b1, 1'b0, 3'b001, 2'b00, 1'b1, 1'b1};
        v[16] = '{32'h1000_0000, 2'b00, 1'b1, 1'b0, 3'b010, 2'b10, 1'b1, 1'b0};
        v[17] = '{32'h3000_0000, 2'b10, 1'b0, 1'b0, 3'b000, 2'b01, 1'b0, 1'b0};
        v[18] = '{32'h3000_0000, 2'b10, 1'b1, 1'b0, 3'b000, 2'b01, 1'b1, 1'b0};
        v[19] = '{32'h0000_0000, 2'b00, 1'b1, 1'b0, 3'b001, 2'b00, 1'b0, 1'b1};
        v[20] = '{32'h0000_0000, 2'b00, 1'b1, 1'b0, 3'b001, 2'b00, 1'b1, 1'b1};
        v[21] = '{32'h0000_0000, 2'b00, 1'b1, 1'b0, 3'b001, 2'b10, 1'b1, 1'b0};

        HRESETn = 1'b0;
        HADDR = 32'h1000_0000;
        HTRANS = 2'b00;
        HREADYOUT_I = 1'b1;
        HRESP_I = 1'b0;
        repeat (3) begin
            @(negedge HCLK);
            check_all("reset", 3'b010, 2'b00, 1'b1, 1'b0);
        end

        for (int i = 0; i < 22; i++) begin
            @(posedge HCLK);
            #1;
            if (i == 0) HRESETn = 1'b1;
            HADDR = v[i].addr;
            HTRANS = v[i].trans;
            HREADYOUT_I = v[i].ro;
            HRESP_I = v[i].ri;
            @(negedge HCLK);
            check_all($sformatf("vec%0d", i), v[i].hsel, v[i].msel, v[i].rdy, v[i].rsp);
        end

        // Reset pulled while the default slave is in its first error cycle
        @(posedge HCLK);
        #1;
        HADDR = 32'h3000_0000;
        HTRANS = 2'b10;
        @(negedge HCLK);
        check_all("pre_err", 3'b000, 2'b10, 1'b1, 1'b0);
        @(posedge HCLK);
        #1;
        HADDR = 32'h6000_0000;
        HTRANS = 2'b00;
        #1;
        check_all("err1", 3'b000, 2'b00, 1'b0, 1'b1);
        HRESETn = 1'b0;
        #1;
        check_all("rst_in_err1", 3'b000, 2'b00, 1'b1, 1'b0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        @(negedge HCLK);
        check_all("post_rst0", 3'b000, 2'b00, 1'b1, 1'b0);
        @(posedge HCLK);
        @(negedge HCLK);
        check_all("post_rst1", 3'b000, 2'b00, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
